// File: rtl/mmio_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared single-beat
// MMIO write bus. Each grant produces exactly one mmio_req strobe, then waits
// for mmio_done (or a timeout) and returns a one-cycle completion to the
// winning requester.
`timescale 1ns/1ps
module mmio_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_data,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_data,
  output logic        m1_done,
  output logic        m1_err,
  output logic [15:0] mmio_addr,
  output logic [7:0]  mmio_data,
  output logic        mmio_req,
  input  logic        mmio_done,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  // Last WAIT-cycle count value before the transaction is abandoned.
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        w_pick;

  // Requester that wins if IDLE grants this cycle: a lone requester wins,
  // a tie goes to whoever did not win last time.
  always_comb begin
    w_pick = 1'b0;
    if (m0_req && m1_req) begin
      w_pick = ~r_last_grant;
    end else if (m1_req) begin
      w_pick = 1'b1;
    end
  end

  // Transaction sequencer: grant, strobe, wait with timeout, complete.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= 8'd0;
      r_addr       <= 16'd0;
      r_data       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_addr       <= w_pick ? m1_addr : m0_addr;
            r_data       <= w_pick ? m1_data : m0_data;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= 8'd0;
          if (mmio_done) begin
            r_err   <= 1'b0;
            r_state <= S_COMPLETE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (mmio_done) begin
            r_err   <= 1'b0;
            r_state <= S_COMPLETE;
          end else if (r_cnt == C_TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_COMPLETE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_COMPLETE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so reset clears them at once.
  assign mmio_req  = (r_state == S_ISSUE);
  assign busy      = (r_state != S_IDLE);
  assign grant     = r_grant;
  assign mmio_addr = r_addr;
  assign mmio_data = r_data;
  assign m0_done   = (r_state == S_COMPLETE) && !r_grant;
  assign m1_done   = (r_state == S_COMPLETE) &&  r_grant;
  assign m0_err    = m0_done && r_err;
  assign m1_err    = m1_done && r_err;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed reset/latency table,
// timeout and boundary sequences, asynchronous mid-transaction reset, then
// randomized traffic checked against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_mmio_arbiter;
  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [15:0] m0_addr = 16'd0, m1_addr = 16'd0;
  logic [7:0]  m0_data = 8'd0, m1_data = 8'd0;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data;
  logic        mmio_req;
  logic        mmio_done = 1'b0;
  logic        grant, busy;

  int checks = 0;
  int errors = 0;
  int cyc_ctr = 0;
  logic [7:0] led_reg = 8'h00;

  mmio_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_data(m0_data), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_data(m1_data), .m1_done(m1_done), .m1_err(m1_err),
    .mmio_addr(mmio_addr), .mmio_data(mmio_data), .mmio_req(mmio_req), .mmio_done(mmio_done),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  // Cycle counter, read only at negedges.
  always @(posedge clock) cyc_ctr <= cyc_ctr + 1;

  // LED peripheral register at 0xF000 captures data on the strobe.
  always @(posedge clock) if (mmio_req && mmio_addr == 16'hF000) led_reg <= mmio_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (mmio_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, " strobe"}, 32'(mmio_req), 32'd1);
  endtask

  typedef struct {
    logic       m0r;
    logic [7:0] m0d;
    logic       m1r;
    logic [7:0] m1d;
    logic       dn;
    logic       e_req;
    logic       e_busy;
    logic       e_grant;
    logic       e_d0;
    logic       e_d1;
    logic       e_err;
    logic [7:0] e_data;
    logic [7:0] e_led;
  } vec_t;

  vec_t tbl[18];

  // Random-phase state (reference model and requester agents).
  logic        a_req[2];
  logic [15:0] a_addr[2];
  logic [7:0]  a_data[2];
  int          m_strobe, m_done_cyc, m_win, m_last, pulse_cyc, d;
  logic        m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic        e_busy, e_done, sdone;
  int          t_s, n;

  initial begin
    // m0r  m0d    m1r  m1d    dn   | req  busy grnt d0   d1   err  data   led
    tbl[0]  = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[1]  = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 8'h55};
    tbl[2]  = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 8'h2A};
    tbl[3]  = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2A, 8'h2A};
    tbl[4]  = '{1'b0, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2A};
    tbl[5]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2A};
    tbl[6]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h2A};
    tbl[7]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02};
    tbl[8]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02};
    tbl[9]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02};
    tbl[10] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02};
    tbl[11] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01};
    tbl[12] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01};
    tbl[13] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
    tbl[14] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h01};
    tbl[15] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02};
    tbl[16] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02};
    tbl[17] = '{1'b0, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02};

    // ---- Reset held with a pending request ----
    m0_req = 1'b1; m0_addr = 16'hF000; m0_data = 8'h55;
    repeat (3) @(negedge clock);
    chk("rst mmio_req", 32'(mmio_req), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst m0_done", 32'(m0_done), 32'd0);
    chk("rst m1_done", 32'(m1_done), 32'd0);
    chk("rst m0_err", 32'(m0_err), 32'd0);
    chk("rst m1_err", 32'(m1_err), 32'd0);
    chk("rst mmio_addr", 32'(mmio_addr), 32'd0);
    chk("rst mmio_data", 32'(mmio_data), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel mmio_req", 32'(mmio_req), 32'd1);
    chk("rel mmio_addr", 32'(mmio_addr), 32'hF000);
    chk("rel mmio_data", 32'(mmio_data), 32'h55);
    @(negedge clock);
    mmio_done = 1'b1;
    @(negedge clock);
    mmio_done = 1'b0;
    chk("rel m0_done", 32'(m0_done), 32'd1);
    m0_req = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // ---- Table: single write then contention ----
    m0_addr = 16'hF000; m1_addr = 16'hF000;
    for (int i = 0; i < 18; i++) begin
      m0_req = tbl[i].m0r; m0_data = tbl[i].m0d;
      m1_req = tbl[i].m1r; m1_data = tbl[i].m1d;
      mmio_done = tbl[i].dn;
      chk($sformatf("vec%0d mmio_req", i), 32'(mmio_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d m0_done", i), 32'(m0_done), 32'(tbl[i].e_d0));
      chk($sformatf("vec%0d m1_done", i), 32'(m1_done), 32'(tbl[i].e_d1));
      chk($sformatf("vec%0d m0_err", i), 32'(m0_err), 32'(tbl[i].e_d0 & tbl[i].e_err));
      chk($sformatf("vec%0d m1_err", i), 32'(m1_err), 32'(tbl[i].e_d1 & tbl[i].e_err));
      chk($sformatf("vec%0d led", i), 32'(led_reg), 32'(tbl[i].e_led));
      if (tbl[i].e_busy) begin
        chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
        chk($sformatf("vec%0d mmio_data", i), 32'(mmio_data), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d mmio_addr", i), 32'(mmio_addr), 32'hF000);
      end
      @(negedge clock);
    end
    mmio_done = 1'b0;

    // ---- Timeout on an unmapped address (requester 1) ----
    m1_req = 1'b1; m1_addr = 16'h1234; m1_data = 8'h77;
    wait_strobe("tmo");
    t_s = cyc_ctr;
    chk("tmo grant", 32'(grant), 32'd1);
    @(negedge clock);
    chk("tmo strobe width", 32'(mmio_req), 32'd0);
    n = 0;
    while (m1_done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("tmo latency", 32'(cyc_ctr - t_s), 32'(TIMEOUT + 1));
    chk("tmo m1_done", 32'(m1_done), 32'd1);
    chk("tmo m1_err", 32'(m1_err), 32'd1);
    chk("tmo m0_done", 32'(m0_done), 32'd0);
    m1_req = 1'b0;
    @(negedge clock);
    chk("tmo busy after", 32'(busy), 32'd0);

    // ---- Done on the final WAIT cycle wins over the timeout ----
    m0_req = 1'b1; m0_addr = 16'h2222; m0_data = 8'h33;
    wait_strobe("bnd");
    repeat (TIMEOUT) @(negedge clock);
    chk("bnd still waiting", 32'(m0_done), 32'd0);
    mmio_done = 1'b1;
    @(negedge clock);
    mmio_done = 1'b0;
    chk("bnd m0_done", 32'(m0_done), 32'd1);
    chk("bnd m0_err", 32'(m0_err), 32'd0);
    m0_req = 1'b0;
    @(negedge clock);

    // ---- Done one cycle too late: timeout already fired, stray ignored ----
    m0_req = 1'b1; m0_data = 8'h34;
    wait_strobe("late");
    repeat (TIMEOUT + 1) @(negedge clock);
    chk("late m0_done", 32'(m0_done), 32'd1);
    chk("late m0_err", 32'(m0_err), 32'd1);
    mmio_done = 1'b1;
    m0_req = 1'b0;
    @(negedge clock);
    mmio_done = 1'b0;
    chk("late busy", 32'(busy), 32'd0);
    chk("late no done", 32'(m0_done | m1_done), 32'd0);

    // ---- Asynchronous reset during WAIT ----
    m0_req = 1'b1; m0_addr = 16'h3333; m0_data = 8'h44;
    wait_strobe("mrst");
    repeat (3) @(negedge clock);
    chk("mrst busy before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst mmio_req", 32'(mmio_req), 32'd0);
    chk("mrst done", 32'(m0_done | m1_done), 32'd0);
    chk("mrst err", 32'(m0_err | m1_err), 32'd0);
    m0_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("mrst no done %0d", k), 32'(m0_done | m1_done), 32'd0);
    end
    m0_req = 1'b1; m0_addr = 16'hF000; m0_data = 8'h10;
    m1_req = 1'b1; m1_addr = 16'hF000; m1_data = 8'h20;
    wait_strobe("mrst tie");
    chk("mrst tie grant", 32'(grant), 32'd0);
    chk("mrst tie data", 32'(mmio_data), 32'h10);

    // ---- Randomized traffic against the timing model ----
    m0_req = 1'b0; m1_req = 1'b0; mmio_done = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    a_req[0] = 1'b0; a_req[1] = 1'b0;
    a_addr[0] = 16'd0; a_addr[1] = 16'd0;
    a_data[0] = 8'd0; a_data[1] = 8'd0;
    m_strobe = -10; m_done_cyc = -20; m_win = 0; m_last = 1; pulse_cyc = -1;
    m_err = 1'b0; m_addr = 16'd0; m_data = 8'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      e_busy = (cyc >= m_strobe) && (cyc <= m_done_cyc);
      e_done = (cyc == m_done_cyc);
      chk("rnd busy", 32'(busy), 32'(e_busy));
      chk("rnd mmio_req", 32'(mmio_req), 32'(cyc == m_strobe));
      chk("rnd m0_done", 32'(m0_done), 32'(e_done && m_win == 0));
      chk("rnd m1_done", 32'(m1_done), 32'(e_done && m_win == 1));
      chk("rnd m0_err", 32'(m0_err), 32'(e_done && m_win == 0 && m_err));
      chk("rnd m1_err", 32'(m1_err), 32'(e_done && m_win == 1 && m_err));
      if (e_busy) begin
        chk("rnd grant", 32'(grant), 32'(m_win));
        chk("rnd mmio_addr", 32'(mmio_addr), 32'(m_addr));
        chk("rnd mmio_data", 32'(mmio_data), 32'(m_data));
      end
      // Requester agents: drop on done, otherwise occasionally start a write.
      for (int k = 0; k < 2; k++) begin
        if (a_req[k] && ((k == 0) ? m0_done : m1_done)) begin
          a_req[k] = 1'b0;
        end else if (!a_req[k] && $urandom_range(0, 3) == 0) begin
          a_req[k]  = 1'b1;
          a_addr[k] = ($urandom_range(0, 2) != 0) ? 16'hF000 : 16'($urandom_range(0, 16'hEFFF));
          a_data[k] = 8'($urandom);
        end
      end
      m0_req = a_req[0]; m0_addr = a_addr[0]; m0_data = a_data[0];
      m1_req = a_req[1]; m1_addr = a_addr[1]; m1_data = a_data[1];
      sdone = (cyc >= m_done_cyc) && ($urandom_range(0, 7) == 0);
      mmio_done = (cyc == pulse_cyc) || sdone;
      // Bus idle this cycle: the model picks the next winner.
      if (cyc > m_done_cyc && (a_req[0] || a_req[1])) begin
        m_win = (a_req[0] && a_req[1]) ? (1 - m_last) : (a_req[0] ? 0 : 1);
        m_last = m_win;
        m_strobe = cyc + 1;
        m_addr = a_addr[m_win];
        m_data = a_data[m_win];
        if (m_addr == 16'hF000) begin
          case ($urandom_range(0, 3))
            0: d = 0;
            1: d = TIMEOUT;
            default: d = int'($urandom_range(0, TIMEOUT));
          endcase
          pulse_cyc = m_strobe + d;
          m_done_cyc = m_strobe + d + 1;
          m_err = 1'b0;
        end else begin
          pulse_cyc = -1;
          m_done_cyc = m_strobe + TIMEOUT + 1;
          m_err = 1'b1;
        end
      end
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
